// File: rtl/sdram_host_port.sv
// Host-side front end for an SDRAM controller. Queues host requests in a small FIFO
// and arbitrates between queued commands and periodic auto-refresh requests.
module sdram_host_port #(
  parameter int DEPTH        = 4,
  parameter int REF_INTERVAL = 780
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic        host_we,
  input  logic [20:0] host_addr,
  input  logic [15:0] host_wdata,
  input  logic [1:0]  host_be,
  input  logic        init_done,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_we,
  output logic [1:0]  cmd_ba,
  output logic [10:0] cmd_row,
  output logic [7:0]  cmd_col,
  output logic [15:0] cmd_wdata,
  output logic [1:0]  cmd_dqm,
  output logic        ref_req,
  input  logic        ref_ack,
  output logic        ref_overrun
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

  typedef struct packed {
    logic        we;
    logic [20:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
  } entry_t;

  typedef enum logic [1:0] {IDLE, CMD, REF} state_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            ref_pending_q, ref_pending_d;
  logic            ref_overrun_q, ref_overrun_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic            ref_req_q, ref_req_d;
  logic            push, pop, wrap, ack_eff;

  assign host_ready = (count_q < CW'(DEPTH));
  // A full FIFO stays not-ready even when a pop happens in the same cycle.
  assign push       = host_valid && host_ready;
  assign pop        = cmd_valid_q && cmd_ready;
  assign ack_eff    = ref_ack && (state_q == REF);
  assign wrap       = init_done && (timer_q == TW'(REF_INTERVAL - 1));

  always_comb begin
    wr_ptr_d      = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d      = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d       = count_q + CW'(push) - CW'(pop);
    timer_d       = timer_q;
    if (init_done) timer_d = wrap ? '0 : timer_q + TW'(1);
    // A wrap coinciding with the ack starts a fresh pending interval.
    ref_pending_d = (ref_pending_q && !ack_eff) || wrap;
    ref_overrun_d = ref_overrun_q || (wrap && ref_pending_q);

    state_d = state_q;
    case (state_q)
      IDLE: if (init_done) begin
              if (ref_pending_q)       state_d = REF;
              else if (count_q != '0)  state_d = CMD;
            end
      CMD:  if (cmd_ready) state_d = IDLE;
      REF:  if (ref_ack)   state_d = IDLE;
      default:             state_d = IDLE;
    endcase
    cmd_valid_d = (state_d == CMD);
    ref_req_d   = (state_d == REF);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      timer_q       <= '0;
      ref_pending_q <= 1'b0;
      ref_overrun_q <= 1'b0;
      cmd_valid_q   <= 1'b0;
      ref_req_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      timer_q       <= timer_d;
      ref_pending_q <= ref_pending_d;
      ref_overrun_q <= ref_overrun_d;
      cmd_valid_q   <= cmd_valid_d;
      ref_req_q     <= ref_req_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= '{we: host_we, addr: host_addr, wdata: host_wdata, be: host_be};
  end

  assign head        = mem[rd_ptr_q];
  assign cmd_valid   = cmd_valid_q;
  assign ref_req     = ref_req_q;
  assign ref_overrun = ref_overrun_q;
  assign cmd_we      = head.we;
  assign cmd_ba      = head.addr[20:19];
  assign cmd_row     = head.addr[18:8];
  assign cmd_col     = head.addr[7:0];
  assign cmd_wdata   = head.wdata;
  assign cmd_dqm     = ~head.be;

endmodule

// File: tb/tb_sdram_host_port.sv
// Randomized and directed bench for sdram_host_port: a negedge monitor compares DUT
// outputs against a queue/tick-count reference model fed from the host side.
module tb_sdram_host_port;
  localparam int DEPTH = 4;
  localparam int RI    = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        host_valid = 1'b0, host_ready, host_we = 1'b0;
  logic [20:0] host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic [1:0]  host_be = '0;
  logic        init_done = 1'b0;
  logic        cmd_valid, cmd_ready = 1'b0, cmd_we;
  logic [1:0]  cmd_ba, cmd_dqm;
  logic [10:0] cmd_row;
  logic [7:0]  cmd_col;
  logic [15:0] cmd_wdata;
  logic        ref_req, ref_ack = 1'b0, ref_overrun;

  int checks = 0;
  int errors = 0;

  sdram_host_port #(.DEPTH(DEPTH), .REF_INTERVAL(RI)) dut (
    .clk(clk), .rst(rst),
    .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_be(host_be),
    .init_done(init_done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_ba(cmd_ba), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .cmd_wdata(cmd_wdata), .cmd_dqm(cmd_dqm),
    .ref_req(ref_req), .ref_ack(ref_ack), .ref_overrun(ref_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected command image built from the host request with plain arithmetic.
  function automatic logic [39:0] expect_cmd(input logic we, input int a, input logic [15:0] wd,
                                             input int be);
    logic [1:0]  ba;
    logic [10:0] row;
    logic [7:0]  col;
    logic [1:0]  dqm;
    ba  = 2'(a / 524288);
    row = 11'((a / 256) % 2048);
    col = 8'(a % 256);
    dqm = 2'(3 - be);
    return {we, ba, row, col, wd, dqm};
  endfunction

  // Reference model state
  logic [39:0] expq[$];
  int          mtick = 0;
  bit          mpend = 0, movr = 0;
  bit          prev_cv = 0, prev_cr = 0, prev_pend = 0;
  logic [39:0] prev_act = '0;

  always @(negedge clk) begin
    logic [39:0] act;
    int          n;
    bit          ack, wrap;
    if (rst) begin
      expq.delete();
      mtick = 0; mpend = 0; movr = 0;
      prev_cv = 0; prev_cr = 0; prev_pend = 0;
    end else begin
      act = {cmd_we, cmd_ba, cmd_row, cmd_col, cmd_wdata, cmd_dqm};
      n   = expq.size();
      chk("host_ready", host_ready, 64'(n < DEPTH));
      chk("ref_overrun", ref_overrun, 64'(movr));
      if (ref_req) chk("ref_req_without_pending", 64'(mpend), 1);
      if (cmd_valid && !prev_cv) chk("ref_priority", 64'(prev_pend), 0);
      if (cmd_valid && prev_cv && !prev_cr) chk("payload_stable", act, prev_act);
      if (cmd_valid) begin
        if (n == 0) chk("cmd_unexpected", cmd_valid, 0);
        else        chk("cmd_payload", act, expq[0]);
      end
      prev_cv = cmd_valid; prev_cr = cmd_ready; prev_act = act; prev_pend = mpend;
      if (cmd_valid && cmd_ready && n > 0) expq.pop_front();
      if (host_valid && n < DEPTH)
        expq.push_back(expect_cmd(host_we, int'(host_addr), host_wdata, int'(host_be)));
      ack  = ref_ack && ref_req;
      wrap = 0;
      if (init_done) begin
        mtick++;
        if (mtick == RI) begin mtick = 0; wrap = 1; end
      end
      if (wrap && mpend) movr = 1;
      mpend = (mpend && !ack) || wrap;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; host_valid = 0; cmd_ready = 0; ref_ack = 0; init_done = 0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic set_host(input logic v, input logic we, input logic [20:0] a, input logic [1:0] be);
    host_valid = v; host_we = we; host_addr = a; host_be = be;
    host_wdata = 16'($urandom);
  endtask

  task automatic drain(input int cycles, output int got);
    got = 0;
    host_valid = 0; init_done = 1; cmd_ready = 1;
    repeat (cycles) begin
      ref_ack = ref_req;
      if (cmd_valid) got++;
      step();
    end
    cmd_ready = 0; ref_ack = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, got, first;
    #3;
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_ref_req", ref_req, 0);
    chk("rst_host_ready", host_ready, 1);
    chk("rst_ref_overrun", ref_overrun, 0);
    step();
    do_reset();

    // No command before init_done, correct decode once it rises, then 2-cycle latency.
    set_host(1, 1, 21'h1_2345, 2'b01);
    step();
    host_valid = 0;
    cnt = 0;
    repeat (20) begin step(); if (cmd_valid) cnt++; end
    chk("no_cmd_before_init", cnt, 0);
    init_done = 1;
    for (int k = 0; k < 10 && !cmd_valid; k++) step();
    chk("init_cmd_valid", cmd_valid, 1);
    chk("init_ba", cmd_ba, 0);
    chk("init_row", cmd_row, 11'h123);
    chk("init_col", cmd_col, 8'h45);
    chk("init_dqm", cmd_dqm, 2'b10);
    chk("init_we", cmd_we, 1);
    cmd_ready = 1; step(); cmd_ready = 0;
    step();
    set_host(1, 0, 21'h1F_FFFF, 2'b11);
    step();
    host_valid = 0;
    chk("latency_n1", cmd_valid, 0);
    step();
    chk("latency_n2", cmd_valid, 1);
    drain(10, got);

    // Fill to DEPTH, refuse the fifth and a push coinciding with a pop at full.
    do_reset();
    init_done = 1;
    for (int i = 0; i < 5; i++) begin
      set_host(1, 1'($urandom), 21'($urandom), 2'($urandom));
      chk("fill_host_ready", host_ready, 64'(i < DEPTH));
      step();
    end
    chk("full_cmd_valid", cmd_valid, 1);
    chk("full_host_ready", host_ready, 0);
    cmd_ready = 1; step(); cmd_ready = 0; host_valid = 0;
    chk("pop_at_full_ready", host_ready, 1);
    drain(20, got);
    chk("pop_at_full_count", got, 3);

    // Refresh becomes pending behind a stalled command and wins the next slot.
    do_reset();
    init_done = 1;
    for (int i = 0; i < 3; i++) begin
      set_host(1, 1'($urandom), 21'($urandom), 2'($urandom));
      step();
    end
    host_valid = 0;
    repeat (17) step();
    chk("stalled_cmd_valid", cmd_valid, 1);
    cmd_ready = 1; step();
    first = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (ref_req) begin first = 1; break; end
      if (cmd_valid) begin first = 2; break; end
    end
    chk("ref_before_cmd", first, 1);
    ref_ack = 1; step(); ref_ack = 0;
    got = 0;
    for (int k = 0; k < 8 && got == 0; k++) begin
      if (cmd_valid) got = 1; else step();
    end
    chk("cmd_after_ref", got, 1);
    drain(20, got);

    // Withheld ack across two wraps sets the sticky overrun flag.
    do_reset();
    init_done = 1;
    repeat (20) step();
    chk("ovr_after_one_wrap", ref_overrun, 0);
    repeat (20) step();
    chk("ovr_after_two_wraps", ref_overrun, 1);
    chk("ovr_ref_req", ref_req, 1);
    ref_ack = 1; step(); ref_ack = 0; step();
    chk("ovr_sticky", ref_overrun, 1);
    chk("ovr_ref_req_cleared", ref_req, 0);

    // Random traffic, random back-pressure, stray acks, occasional init_done dips.
    do_reset();
    init_done = 1;
    repeat (800) begin
      set_host(1'($urandom_range(3) != 0), 1'($urandom), 21'($urandom), 2'($urandom));
      cmd_ready = 1'($urandom);
      ref_ack   = ($urandom_range(2) == 0);
      init_done = ($urandom_range(39) != 0);
      step();
    end
    drain(40, got);
    chk("random_all_delivered", expq.size(), 0);

    // Asynchronous reset with entries queued while a refresh is requested.
    do_reset();
    init_done = 1;
    for (int k = 0; k < 30 && !ref_req; k++) step();
    for (int i = 0; i < 3; i++) begin
      set_host(1, 1, 21'($urandom), 2'b11);
      step();
    end
    host_valid = 0;
    chk("pre_rst_ref_req", ref_req, 1);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_cmd_valid", cmd_valid, 0);
    chk("async_rst_ref_req", ref_req, 0);
    chk("async_rst_host_ready", host_ready, 1);
    step(); step();
    rst = 1'b0;
    cnt = 0;
    repeat (10) begin step(); if (cmd_valid) cnt++; end
    chk("no_stale_cmd", cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
